// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage control-transfer resolver: condition
// codes, flag bit positions, FSM states and control-instruction decode.
package branch_pkg;

  localparam logic [3:0] COND_EQ     = 4'd0;
  localparam logic [3:0] COND_NE     = 4'd1;
  localparam logic [3:0] COND_GT     = 4'd2;
  localparam logic [3:0] COND_LT     = 4'd3;
  localparam logic [3:0] COND_GE     = 4'd4;
  localparam logic [3:0] COND_LE     = 4'd5;
  localparam logic [3:0] COND_OV     = 4'd6;
  localparam logic [3:0] COND_ALWAYS = 4'd7;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    IDLE,
    EXEC_PEND
  } bcu_state_e;

  typedef enum logic [2:0] {
    CTL_NONE,
    CTL_BRANCH,
    CTL_JAL,
    CTL_JR,
    CTL_EXEC
  } ctl_kind_e;

  // Several control bits may be set at once; EXEC wins, then JR, JAL, branch.
  function automatic ctl_kind_e decode_kind(input logic is_branch,
                                            input logic is_jal,
                                            input logic is_jr,
                                            input logic is_exec);
    ctl_kind_e kind;
    kind = CTL_NONE;
    if (is_exec)        kind = CTL_EXEC;
    else if (is_jr)     kind = CTL_JR;
    else if (is_jal)    kind = CTL_JAL;
    else if (is_branch) kind = CTL_BRANCH;
    return kind;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 4-bit branch condition code against the
// previous instruction's Z/V/N flags. Reserved codes are never taken.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       cond_true_o
);

  logic flag_z;
  logic flag_v;
  logic flag_n;

  assign flag_z = flags_i[FLAG_Z];
  assign flag_v = flags_i[FLAG_V];
  assign flag_n = flags_i[FLAG_N];

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      COND_EQ:     cond_true_o = flag_z;
      COND_NE:     cond_true_o = !flag_z;
      COND_GT:     cond_true_o = !flag_z && !flag_n;
      COND_LT:     cond_true_o = flag_n;
      COND_GE:     cond_true_o = flag_z || !flag_n;
      COND_LE:     cond_true_o = flag_z || flag_n;
      COND_OV:     cond_true_o = flag_v;
      COND_ALWAYS: cond_true_o = 1'b1;
      default:     cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// EX-stage control-transfer resolver: decides branches/JAL/JR/EXEC, issues the
// PC redirect in the same cycle and squashes the younger wrong-path slots.
//
// Handshake: an instruction is consumed from EX on any cycle with
// ex_advance=1; ex_valid=1 marks it as a real instruction rather than a bubble.
// Squash state and the decision only move on consuming cycles, so ex_advance=0
// is a pure stall that freezes everything.
module branch_ctrl_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int FLUSH_DEPTH = 3,
  parameter int NT_BUBBLES  = 0,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_advance,
  input  logic              is_branch,
  input  logic              is_jal,
  input  logic              is_jr,
  input  logic              is_exec,
  input  logic [3:0]        cond,
  input  logic [2:0]        flags,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc_plus1,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              squash_alu,
  output logic              squash_ld,
  output logic              squash_st,
  output logic              exec_active
);

  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_DEPTH);
  localparam logic [CNT_W-1:0] NT_CNT    = CNT_W'(NT_BUBBLES);

  bcu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;

  logic              cond_true;
  logic              squash_active;
  logic              decide;
  logic              taken;
  logic              redirect_raw;
  logic [ADDR_W-1:0] redirect_pc_raw;
  ctl_kind_e         kind;

  branch_cond_eval u_cond_eval (
    .cond_i      (cond),
    .flags_i     (flags),
    .cond_true_o (cond_true)
  );

  assign squash_active = (sq_cnt_q != '0);
  assign decide        = ex_valid && ex_advance && !squash_active;
  assign kind          = decode_kind(is_branch, is_jal, is_jr, is_exec);

  always_comb begin
    state_d         = state_q;
    sq_cnt_d        = sq_cnt_q;
    ret_pc_d        = ret_pc_q;
    taken           = 1'b0;
    redirect_raw    = 1'b0;
    redirect_pc_raw = '0;

    if (ex_advance && squash_active) begin
      sq_cnt_d = sq_cnt_q - CNT_W'(1);
    end

    if (decide) begin
      unique case (state_q)
        IDLE: begin
          case (kind)
            CTL_EXEC: begin
              taken    = 1'b1;
              state_d  = EXEC_PEND;
              ret_pc_d = pc_plus1;
            end
            CTL_JR, CTL_JAL: taken = 1'b1;
            CTL_BRANCH: begin
              taken = cond_true;
              if (!cond_true) sq_cnt_d = NT_CNT;
            end
            default: taken = 1'b0;
          endcase
          // A taken transfer to the fall-through address needs no redirect
          // and leaves the already-fetched younger instructions valid.
          if (taken && (target != pc_plus1)) begin
            redirect_raw    = 1'b1;
            redirect_pc_raw = target;
            sq_cnt_d        = FLUSH_CNT;
          end
        end
        EXEC_PEND: begin
          // The exec'd instruction's own control bits are deliberately ignored.
          redirect_raw    = 1'b1;
          redirect_pc_raw = ret_pc_q;
          sq_cnt_d        = FLUSH_CNT;
          state_d         = IDLE;
        end
      endcase
    end
  end

  // Reset also masks the combinational redirect so nothing escapes that cycle.
  assign redirect    = redirect_raw && !rst;
  assign redirect_pc = redirect ? redirect_pc_raw : '0;
  assign squash_alu  = squash_active;
  assign squash_ld   = squash_active;
  assign squash_st   = squash_active;
  assign exec_active = (state_q == EXEC_PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sq_cnt_q <= '0;
      ret_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      ret_pc_q <= ret_pc_d;
    end
  end

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Self-checking bench for branch_ctrl_unit (FLUSH_DEPTH=3, NT_BUBBLES=1).
// Expected outputs are queued as each cycle's stimulus is driven.
module tb_branch_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_advance;
  logic        is_branch, is_jal, is_jr, is_exec;
  logic [3:0]  cond;
  logic [2:0]  flags;
  logic [15:0] target, pc_plus1;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        squash_alu, squash_ld, squash_st, exec_active;

  logic [20:0] exp_q[$];
  logic [20:0] got, exp_v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  branch_ctrl_unit #(
    .ADDR_W(16), .FLUSH_DEPTH(3), .NT_BUBBLES(1), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_advance(ex_advance),
    .is_branch(is_branch), .is_jal(is_jal), .is_jr(is_jr), .is_exec(is_exec),
    .cond(cond), .flags(flags), .target(target), .pc_plus1(pc_plus1),
    .redirect(redirect), .redirect_pc(redirect_pc), .squash_alu(squash_alu),
    .squash_ld(squash_ld), .squash_st(squash_st), .exec_active(exec_active)
  );

  // Reference condition table written directly from the condition-code list.
  function automatic logic cond_ref(input logic [3:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return !z && !n;
      4'd3: return n;
      4'd4: return z || !n;
      4'd5: return z || n;
      4'd6: return v;
      4'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs and queue that cycle's expected outputs.
  task automatic apply(input logic r, v, a, br, jl, jrr, ex,
                       input logic [3:0] c, input logic [2:0] f,
                       input logic [15:0] t, p,
                       input logic e_red, input logic [15:0] e_pc,
                       input logic e_sq, e_ea);
    rst = r; ex_valid = v; ex_advance = a;
    is_branch = br; is_jal = jl; is_jr = jrr; is_exec = ex;
    cond = c; flags = f; target = t; pc_plus1 = p;
    exp_q.push_back({e_red, e_pc, e_sq, e_sq, e_sq, e_ea});
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) apply(1,1,1,0,1,0,0, 4'd0,3'd0,16'h0055,16'h0010, 0,16'h0,0,0);
      else       apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0010+i, 0,16'h0,0,0);
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_idle step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_beq;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       apply(0,1,1,1,0,0,0, 4'd0,3'b100,16'h0020,16'h0011, 1,16'h0020,0,0);
        1,2,3:   apply(0,1,1,0,1,0,0, 4'd0,3'd0,16'h0077,16'h0021+i, 0,16'h0,1,0);
        default: apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0025, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL beq step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_bgt_not_taken;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       apply(0,1,1,1,0,0,0, 4'd2,3'b001,16'h0030,16'h0021, 0,16'h0,0,0);
        1:       apply(0,1,1,1,0,0,0, 4'd7,3'd0,16'h0090,16'h0022, 0,16'h0,1,0);
        default: apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0023, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL bgt_nt step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_cond_sweep;
    logic [2:0]  f;
    logic        tk;
    logic [15:0] tgt;
    int          n;
    for (int c = 0; c < 16; c++) begin
      for (int rep = 0; rep < 2; rep++) begin
        f   = 3'($urandom_range(0, 7));
        tk  = cond_ref(4'(c), f);
        tgt = 16'h0100 + 16'(c);
        n   = tk ? 3 : 1;
        for (int k = 0; k <= n; k++) begin
          if (k == 0) apply(0,1,1,1,0,0,0, 4'(c),f,tgt,16'h0050, tk,tk ? tgt : 16'h0,0,0);
          else        apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0,16'h0, 0,16'h0,1,0);
          @(negedge clk);
          got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
          exp_v = exp_q.pop_front();
          checks++;
          if (got !== exp_v) begin
            errors++;
            $display("FAIL cond_sweep cond %0d flags %b step %0d got %h exp %h",
                     c, f, k, got, exp_v);
          end
          next_cycle();
        end
      end
    end
  endtask

  task automatic test_exec;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       apply(0,1,1,0,0,0,1, 4'd0,3'd0,16'h0040,16'h0031, 1,16'h0040,0,0);
        1,2,3:   apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0032, 0,16'h0,1,1);
        4:       apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0000, 0,16'h0,0,1);
        5:       apply(0,1,1,0,0,1,0, 4'd0,3'd0,16'h0099,16'h0041, 1,16'h0031,0,1);
        6,7,8:   apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0042, 0,16'h0,1,0);
        default: apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0031, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL exec step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_exec_same_target;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       apply(0,1,1,0,0,0,1, 4'd0,3'd0,16'h0022,16'h0022, 0,16'h0,0,0);
        1:       apply(0,1,0,0,0,0,1, 4'd0,3'd0,16'h0070,16'h0023, 0,16'h0,0,1);
        2:       apply(0,1,1,0,0,0,1, 4'd0,3'd0,16'h0070,16'h0023, 1,16'h0022,0,1);
        3,4,5:   apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0024, 0,16'h0,1,0);
        6:       apply(0,1,1,0,1,0,0, 4'd0,3'd0,16'h0033,16'h0033, 0,16'h0,0,0);
        default: apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0034, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL exec_same_tgt step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_jal_stall;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:         apply(0,1,1,1,0,0,0, 4'd7,3'd0,16'h0200,16'h0101, 1,16'h0200,0,0);
        1:         apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0102, 0,16'h0,1,0);
        2:         apply(0,1,1,0,1,0,0, 4'd0,3'd0,16'h0300,16'h0103, 0,16'h0,1,0);
        3,4,5,6:   apply(0,1,0,0,1,0,0, 4'd0,3'd0,16'h0300,16'h0104, 0,16'h0,1,0);
        7:         apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0104, 0,16'h0,1,0);
        default:   apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0105, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL jal_stall step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_priority;
    for (int i = 0; i < 17; i++) begin
      case (i)
        0:          apply(0,1,1,1,1,0,0, 4'd8,3'b100,16'h0080,16'h0051, 1,16'h0080,0,0);
        1,2,3:      apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0000, 0,16'h0,1,0);
        4:          apply(0,1,1,1,0,1,0, 4'd0,3'b000,16'h0090,16'h0061, 1,16'h0090,0,0);
        5,6,7:      apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0000, 0,16'h0,1,0);
        8:          apply(0,1,1,1,1,1,1, 4'd7,3'd0,16'h00a0,16'h0071, 1,16'h00a0,0,0);
        9,10,11:    apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0000, 0,16'h0,1,1);
        12:         apply(0,1,1,1,0,0,0, 4'd7,3'd0,16'h0bbb,16'h00a1, 1,16'h0071,0,1);
        13,14,15:   apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0000, 0,16'h0,1,0);
        default:    apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0072, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL priority step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_exec;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       apply(0,1,1,0,0,0,1, 4'd0,3'd0,16'h0040,16'h0031, 1,16'h0040,0,0);
        1,2,3:   apply(0,0,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0000, 0,16'h0,1,1);
        4:       apply(1,1,1,1,0,0,0, 4'd7,3'd0,16'h0500,16'h0032, 0,16'h0,0,1);
        default: apply(0,1,1,0,0,0,0, 4'd0,3'd0,16'h0000,16'h0033, 0,16'h0,0,0);
      endcase
      @(negedge clk);
      got = {redirect, redirect_pc, squash_alu, squash_ld, squash_st, exec_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_exec step %0d got %h exp %h", i, got, exp_v);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_advance = 1'b0;
    is_branch = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_exec = 1'b0;
    cond = 4'd0; flags = 3'd0; target = 16'h0; pc_plus1 = 16'h0;
    next_cycle();
    test_reset();
    test_beq();
    test_bgt_not_taken();
    test_cond_sweep();
    test_exec();
    test_exec_same_target();
    test_jal_stall();
    test_priority();
    test_reset_mid_exec();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl_unit.md
Name: branch_ctrl_unit

Overview:
- EX-stage control-transfer resolver, generalised successor of the single-width branch/exec controller.
- Evaluates conditional branches, JAL, JR and EXEC against the previous instruction's flags, issues the PC redirect, and drives per-instruction squash of the younger wrong-path instructions.
- Handles the EXEC round trip: run one instruction at the target, then return to EXEC's PC+1.
- Sits between the ID/EX register and the PC mux, ALU, load and store paths. Bubble count, address width and not-taken penalty are parametrised.

Parameters:
- ADDR_W, 16, PC/target width.
- FLUSH_DEPTH, 3, younger instructions squashed after any redirect (1..7).
- NT_BUBBLES, 0, instructions squashed after a not-taken branch (0..7).
- CNT_W, 3, squash counter width; must satisfy 2^CNT_W > max(FLUSH_DEPTH, NT_BUBBLES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a real instruction
- ex_advance  in  1  EX instruction leaves EX this cycle
- is_branch  in  1  conditional branch in EX
- is_jal  in  1  jump-and-link in EX
- is_jr  in  1  jump-return in EX
- is_exec  in  1  EXEC in EX
- cond  in  4  branch condition code
- flags  in  3  previous-instruction flags: [2]=Z, [1]=V, [0]=N
- target  in  ADDR_W  resolved target (PC+1+offset, or register for JR)
- pc_plus1  in  ADDR_W  PC+1 of the EX instruction
- redirect  out  1  load redirect_pc into PC
- redirect_pc  out  ADDR_W  new PC
- squash_alu  out  1  kill ALU writeback of the EX instruction
- squash_ld  out  1  kill load of the EX instruction
- squash_st  out  1  kill store of the EX instruction
- exec_active  out  1  EXEC return pending

Behaviour:
- Reset (rst=1 at posedge; wins over all other inputs):
  - state=IDLE, sq_cnt=0, ret_pc=0.
  - redirect, redirect_pc, squash_*, exec_active all 0.
  - Reset mid-EXEC discards the pending return.
- Squash outputs:
  - squash_alu = squash_ld = squash_st = (sq_cnt != 0), registered-state decode.
  - A squashed instruction's control bits are ignored.
  - sq_cnt decrements by 1 on each cycle with ex_advance=1 and sq_cnt!=0; stall (ex_advance=0) freezes it.
- Decision: evaluated only when ex_valid=1, ex_advance=1 and sq_cnt==0; otherwise redirect=0. redirect and redirect_pc are combinational, same cycle as the control instruction in EX.
- Decode priority when several bits are set: exec > jr > jal > branch.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 GT: !Z&&!N
  - 3 LT: N
  - 4 GE: Z||!N
  - 5 LE: Z||N
  - 6 OV: V
  - 7 ALWAYS: 1
  - 8..15: reserved, never taken.
- Taken = (branch && cond true) || jal || jr || exec.
- Taken with target != pc_plus1:
  - redirect=1, redirect_pc=target.
  - sq_cnt<=FLUSH_DEPTH.
- Taken with target == pc_plus1:
  - No redirect, no squash.
  - Exception: EXEC still enters EXEC_PEND with ret_pc=pc_plus1.
- Branch not taken: no redirect; sq_cnt<=NT_BUBBLES.
- The control instruction itself is never squashed by its own decision (JAL link write proceeds).
- State machine (IDLE, EXEC_PEND):
  - IDLE -> EXEC_PEND on a decided EXEC; ret_pc<=pc_plus1.
  - In EXEC_PEND:
    - Wait until sq_cnt==0.
    - The next ex_valid instruction is the exec'd instruction; it runs normally, but its control bits are ignored (no nested branch/EXEC).
    - When it advances: redirect=1, redirect_pc=ret_pc, sq_cnt<=FLUSH_DEPTH, state<=IDLE.
- exec_active = (state==EXEC_PEND).
- Bubbles: ex_valid=0 with ex_advance=1 still decrements sq_cnt, and in EXEC_PEND does not count as the exec'd instruction.

Decomposition:
- Shared package branch_pkg:
  - cond code constants (COND_EQ..COND_ALWAYS)
  - flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0
  - state enum {IDLE, EXEC_PEND}
- One sub-module, branch_cond_eval: combinational (cond, flags) -> cond_true.

Test Plan:
- Reset then idle stream, no control instructions -> redirect=0, squash_*=0, exec_active=0 throughout.
- BEQ cond=0, flags=3'b100, target=0x0020, pc_plus1=0x0011 -> redirect=1 with redirect_pc=0x0020 that cycle; next 3 advancing instructions have squash_*=1; the 4th has 0.
- BGT cond=2, flags=3'b001 with NT_BUBBLES=1 -> redirect=0; exactly 1 following instruction squashed.
- EXEC target=0x0040, pc_plus1=0x0031 -> redirect to 0x0040, exec_active=1; 3 squashes; exec'd instruction (tagged is_jr=1) runs unsquashed with JR ignored; on its advance, redirect_pc=0x0031; 3 more squashes; exec_active=0.
- Taken JAL while sq_cnt=2, then ex_advance=0 for 4 cycles -> JAL ignored; squash_* held 1 with count frozen during stall.
- rst asserted during EXEC_PEND with is_branch=1 taken -> next cycle all outputs 0, no return redirect later.
